// File: rtl/hs_pkg.sv
// Shared definitions for the toggle REQ/ACK handshake blocks: FSM encodings,
// boolean macros and a ceiling-log2 helper.
`ifndef HS_PKG_DEFS
`define HS_PKG_DEFS
`define TRUE  1'b1
`define FALSE 1'b0
`endif

package hs_pkg;

    localparam logic [1:0] HS_IDLE = 2'd0;
    localparam logic [1:0] HS_LOAD = 2'd1;
    localparam logic [1:0] HS_WAIT = 2'd2;

    // Ceiling log2; values of 0 or 1 return 0.
    function automatic int hs_log2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hs_tx_fifo.sv
// DEPTH x WID_DATA circular queue with full/empty/count; pointers carry one
// extra MSB so a full queue is distinguishable from an empty one.
module hs_tx_fifo
    import hs_pkg::*;
#(
    parameter int WID_DATA = 8,
    parameter int DEPTH    = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WID_DATA-1:0]      i_data,
    input  logic                     i_pop,
    output logic [WID_DATA-1:0]      o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [hs_log2(DEPTH):0]  o_count
);

    localparam int AW = hs_log2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WID_DATA-1:0] r_mem [DEPTH];
    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;
    logic                w_do_push;
    logic                w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer advance; wrap falls out of the natural modulo arithmetic.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage array needs no reset: empty/full come from the pointers alone.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/synchronizer.sv
// Two-flop level synchronizer for a single asynchronous control bit.
module Synchronizer (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Metastability filter chain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/hs_tx_sender.sv
// Transmitter endpoint of the toggle REQ/ACK CDC handshake: queues words and
// sends one per REQ toggle. Optional ACK watchdog under HS_TX_TIMEOUT_EN.
module hs_tx_sender
    import hs_pkg::*;
#(
    parameter int WID_DATA   = 8,
    parameter int DEPTH      = 4,
    parameter int TMO_CYCLES = 255
) (
    input  logic                     T_Clock,
    input  logic                     T_Reset,
    input  logic [WID_DATA-1:0]      W_Data,
    input  logic                     W_Valid,
    output logic                     W_Ready,
    output logic [WID_DATA-1:0]      TX_Data,
    output logic                     TX_Req,
    input  logic                     TX_AckAsync,
    output logic                     Idle,
    output logic [hs_log2(DEPTH):0]  Count,
    output logic                     Timeout
);

    logic [1:0]          r_state;
    logic [WID_DATA-1:0] r_tx_data;
    logic                r_tx_req;
    logic                w_ack_s;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [WID_DATA-1:0] w_head;

    assign w_push = W_Valid & ~w_full;
    assign w_pop  = (r_state == HS_IDLE) & ~w_empty;

    Synchronizer u_ack_sync (
        .i_clk   (T_Clock),
        .i_rst_n (T_Reset),
        .i_async (TX_AckAsync),
        .o_sync  (w_ack_s)
    );

    hs_tx_fifo #(
        .WID_DATA (WID_DATA),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .i_clk   (T_Clock),
        .i_rst_n (T_Reset),
        .i_push  (w_push),
        .i_data  (W_Data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (Count)
    );

    // Handshake FSM: data is loaded one cycle ahead of the REQ edge.
    always_ff @(posedge T_Clock or negedge T_Reset) begin
        if (!T_Reset) begin
            r_state   <= HS_IDLE;
            r_tx_data <= '0;
            r_tx_req  <= 1'b0;
        end else begin
            case (r_state)
                HS_IDLE: begin
                    if (!w_empty) begin
                        r_tx_data <= w_head;
                        r_state   <= HS_LOAD;
                    end
                end
                HS_LOAD: begin
                    r_tx_req <= ~r_tx_req;
                    r_state  <= HS_WAIT;
                end
                HS_WAIT: begin
                    if (w_ack_s == r_tx_req) begin
                        r_state <= HS_IDLE;
                    end
                end
                default: begin
                    r_state <= HS_IDLE;
                end
            endcase
        end
    end

    assign TX_Data = r_tx_data;
    assign TX_Req  = r_tx_req;
    assign W_Ready = ~w_full;
    assign Idle    = (r_state == HS_IDLE) & w_empty;

`ifdef HS_TX_TIMEOUT_EN
    localparam int TW = hs_log2(TMO_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_timeout;

    // Watchdog only observes; the transfer keeps waiting after it fires.
    always_ff @(posedge T_Clock or negedge T_Reset) begin
        if (!T_Reset) begin
            r_tmo_cnt <= '0;
            r_timeout <= `FALSE;
        end else if (r_state == HS_LOAD) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == HS_WAIT) && (w_ack_s != r_tx_req) &&
                     (r_timeout == `FALSE)) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
            if (r_tmo_cnt == TMO_LAST) begin
                r_timeout <= `TRUE;
            end
        end
    end

    assign Timeout = r_timeout;
`else
    assign Timeout = `FALSE;
`endif

endmodule

// File: tb/tb_hs_tx_sender.sv
// Randomized self-checking bench for hs_tx_sender with a transaction-level
// model and a behavioural toggle receiver.
module tb_hs_tx_sender;

    localparam int D   = 4;
    localparam int TMO = 16;

    logic       T_Clock = 1'b0;
    logic       T_Reset = 1'b0;
    logic [7:0] W_Data  = 8'h00;
    logic       W_Valid = 1'b0;
    logic       W_Ready;
    logic [7:0] TX_Data;
    logic       TX_Req;
    logic       TX_AckAsync = 1'b0;
    logic       Idle;
    logic [2:0] Count;
    logic       Timeout;

    int n_chk = 0;
    int n_err = 0;

    hs_tx_sender #(.WID_DATA(8), .DEPTH(D), .TMO_CYCLES(TMO)) dut (
        .T_Clock     (T_Clock),
        .T_Reset     (T_Reset),
        .W_Data      (W_Data),
        .W_Valid     (W_Valid),
        .W_Ready     (W_Ready),
        .TX_Data     (TX_Data),
        .TX_Req      (TX_Req),
        .TX_AckAsync (TX_AckAsync),
        .Idle        (Idle),
        .Count       (Count),
        .Timeout     (Timeout)
    );

    always #5 T_Clock = ~T_Clock;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Transaction model: queue of waiting words, one word in flight.
    byte unsigned mq[$];
    logic [7:0]   m_data = 8'h00;
    bit           m_req = 1'b0, m_busy = 1'b0, m_tog = 1'b0, m_push = 1'b0, m_tmo = 1'b0;
    bit   [1:0]   m_ackd = 2'b00;
    int           m_wcnt = 0;

    always @(posedge T_Clock or negedge T_Reset) begin
        if (!T_Reset) begin
            mq.delete();
            m_data = 8'h00; m_req = 1'b0; m_busy = 1'b0; m_tog = 1'b0;
            m_ackd = 2'b00; m_wcnt = 0; m_tmo = 1'b0;
        end else begin
            m_push = W_Valid && (mq.size() < D);
            if (!m_busy && mq.size() > 0) begin
                m_data = mq.pop_front();
                m_busy = 1'b1;
                m_tog  = 1'b1;
            end else if (m_tog) begin
                m_req  = ~m_req;
                m_tog  = 1'b0;
                m_wcnt = 0;
            end else if (m_busy) begin
                if (m_ackd[1] == m_req) m_busy = 1'b0;
                else begin
                    m_wcnt++;
                    if (m_wcnt >= TMO) m_tmo = 1'b1;
                end
            end
            if (m_push) mq.push_back(W_Data);
            m_ackd = {m_ackd[0], TX_AckAsync};
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge T_Clock) begin
        chk("TX_Data", int'(TX_Data), int'(m_data));
        chk("TX_Req",  int'(TX_Req),  int'(m_req));
        chk("W_Ready", int'(W_Ready), int'(mq.size() < D));
        chk("Idle",    int'(Idle),    int'(!m_busy && mq.size() == 0));
        chk("Count",   int'(Count),   mq.size());
`ifdef HS_TX_TIMEOUT_EN
        chk("Timeout", int'(Timeout), int'(m_tmo));
`else
        chk("Timeout", int'(Timeout), 0);
`endif
    end

    // Behavioural receiver: captures on each REQ toggle, echoes ACK after a delay.
    bit           rx_auto = 1'b0, rx_last = 1'b0, rx_pend = 1'b0;
    int           rx_dmin = 1, rx_dmax = 1, rx_cnt = 0;
    logic [7:0]   rx_word = 8'h00;
    byte unsigned rx_words[$];

    always @(negedge T_Clock or negedge T_Reset) begin
        if (!T_Reset) begin
            TX_AckAsync = 1'b0; rx_last = 1'b0; rx_pend = 1'b0; rx_cnt = 0;
        end else if (TX_Req != rx_last) begin
            rx_last = TX_Req;
            rx_word = TX_Data;
            rx_words.push_back(TX_Data);
            rx_pend = 1'b1;
            rx_cnt  = int'($urandom_range(rx_dmax, rx_dmin));
        end else if (rx_pend) begin
            chk("TX_Data_hold", int'(TX_Data), int'(rx_word));
            if (rx_auto) begin
                if (rx_cnt <= 1) begin
                    TX_AckAsync = rx_last;
                    rx_pend     = 1'b0;
                end else rx_cnt--;
            end
        end
    end

    task automatic step();
        @(posedge T_Clock);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (!(Idle && !rx_pend) && k < budget) begin
            step();
            k++;
        end
        chk({name, "_done"}, int'(k < budget), 1);
    endtask

    task automatic pulse_reset();
        #1;
        T_Reset = 1'b0;
        #1;
        chk("rst_req",   int'(TX_Req),  0);
        chk("rst_data",  int'(TX_Data), 0);
        chk("rst_count", int'(Count),   0);
        chk("rst_idle",  int'(Idle),    1);
        chk("rst_ready", int'(W_Ready), 1);
        step();
        step();
        T_Reset = 1'b1;
        step();
    endtask

    task automatic write1(input logic [7:0] d);
        W_Data  = d;
        W_Valid = 1'b1;
        step();
        W_Valid = 1'b0;
    endtask

    byte unsigned wq[$];
    int base;
    int nxt;
    int k;

    initial begin
        // Reset state
        step(); step();
        chk("init_req", int'(TX_Req), 0);
        chk("init_idle", int'(Idle), 1);
        chk("init_timeout", int'(Timeout), 0);
        T_Reset = 1'b1;
        step();

        // 1: single word latency and ACK return
        rx_auto = 1'b1; rx_dmin = 1; rx_dmax = 1;
        base = rx_words.size();
        write1(8'hA5);                                   // edge N
        chk("t1_idle_drop", int'(Idle), 0);
        chk("t1_count", int'(Count), 1);
        step();                                          // N+1
        chk("t1_data", int'(TX_Data), 8'hA5);
        chk("t1_req_before", int'(TX_Req), 0);
        step();                                          // N+2
        chk("t1_req_toggled", int'(TX_Req), 1);
        step(); step(); step();                          // N+5
        chk("t1_idle_n5", int'(Idle), 0);
        step();                                          // N+6
        chk("t1_idle_n6", int'(Idle), 1);
        chk("t1_rx_word", int'(rx_words[base]), 8'hA5);

        // 2: fill with ACK withheld, overflow write ignored
        rx_auto = 1'b0;
        base = rx_words.size();
        for (int i = 1; i <= 6; i++) begin
            W_Data  = 8'(i);
            W_Valid = 1'b1;
            step();
            if (i == 5) begin
                chk("t2_count_full", int'(Count), 4);
                chk("t2_ready_low", int'(W_Ready), 0);
            end
        end
        W_Valid = 1'b0;
        chk("t2_count_after_6th", int'(Count), 4);
        rx_dmin = 2; rx_dmax = 6; rx_auto = 1'b1;
        wait_idle("t2", 500);
        chk("t2_toggles", rx_words.size() - base, 5);
        for (int i = 0; i < 5; i++) chk("t2_order", int'(rx_words[base + i]), i + 1);

        // 3: push on the popping edge, Count held at 2, pointer wrap
        rx_auto = 1'b0;
        base = rx_words.size();
        write1(8'h10); write1(8'h11); write1(8'h12);
        chk("t3_count_pre", int'(Count), 2);
        nxt = 3; rx_dmin = 1; rx_dmax = 3; rx_auto = 1'b1;
        k = 0;
        while (nxt < 10 && k < 2000) begin
            if (!m_busy && mq.size() > 0) begin
                W_Data = 8'(8'h10 + nxt); W_Valid = 1'b1; nxt++;
                step();
                W_Valid = 1'b0;
                chk("t3_count_hold", int'(Count), 2);
            end else step();
            k++;
        end
        chk("t3_all_pushed", nxt, 10);
        wait_idle("t3", 500);
        chk("t3_words", rx_words.size() - base, 10);
        for (int i = 0; i < 10; i++) chk("t3_order", int'(rx_words[base + i]), 8'h10 + i);

        // 4: reset in WAIT with 3 queued
        rx_auto = 1'b0;
        write1(8'h20); write1(8'h21); write1(8'h22); write1(8'h23);
        chk("t4_req_waiting", int'(TX_Req), 1);
        chk("t4_count3", int'(Count), 3);
        pulse_reset();
        base = rx_words.size();
        rx_auto = 1'b1; rx_dmin = 2; rx_dmax = 5;
        write1(8'h5A);
        wait_idle("t4", 200);
        chk("t4_words", rx_words.size() - base, 1);
        chk("t4_word", int'(rx_words[base]), 8'h5A);

`ifdef HS_TX_TIMEOUT_EN
        // 5: ACK watchdog
        pulse_reset();
        rx_auto = 1'b0;
        write1(8'h77);                                   // N
        step(); step();                                  // N+2: enters WAIT
        for (int i = 0; i < 15; i++) step();
        chk("t5_no_timeout_15", int'(Timeout), 0);
        step();
        chk("t5_timeout_16", int'(Timeout), 1);
        chk("t5_req_steady", int'(TX_Req), 1);
        rx_dmin = 1; rx_dmax = 1; rx_auto = 1'b1;
        wait_idle("t5", 200);
        chk("t5_timeout_sticky", int'(Timeout), 1);
`endif

        // 6: 500 random words, random ACK delays
        base = rx_words.size();
        rx_dmin = 1; rx_dmax = 40; rx_auto = 1'b1;
        k = 0;
        while (wq.size() < 500 && k < 60000) begin
            W_Valid = 1'($urandom);
            W_Data  = 8'($urandom);
            if (W_Valid && mq.size() < D) wq.push_back(W_Data);
            step();
            k++;
        end
        W_Valid = 1'b0;
        chk("t6_all_written", wq.size(), 500);
        wait_idle("t6", 2000);
        chk("t6_words", rx_words.size() - base, wq.size());
        for (int i = 0; i < wq.size() && base + i < rx_words.size(); i++)
            chk("t6_order", int'(rx_words[base + i]), int'(wq[i]));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
